// File: rtl/irq_service_master.sv
// Avalon-MM master that services an edge-capture interrupt slave: it writes
// the slave's irq_mask, reacts to the slave's level IRQ by reading the
// edge_capture register, write-one-clears exactly the bits it read, and then
// hands each captured bit to downstream logic as a valid/ready event,
// lowest index first.
module irq_service_master #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 2,
  parameter int MASK_ADDR    = 2,
  parameter int CAPTURE_ADDR = 3,
  parameter int ID_WIDTH     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  irq_in,
  input  logic [DATA_WIDTH-1:0] cfg_mask,
  input  logic                  cfg_load,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_WIDTH-1:0] avm_writedata,
  input  logic [DATA_WIDTH-1:0] avm_readdata,
  input  logic                  avm_readdatavalid,
  input  logic                  avm_waitrequest,
  output logic                  evt_valid,
  output logic [ID_WIDTH-1:0]   evt_id,
  input  logic                  evt_ready,
  output logic                  busy,
  output logic [7:0]            spurious_cnt
);

  localparam logic [2:0] S_MASK_WR  = 3'd0;
  localparam logic [2:0] S_IDLE     = 3'd1;
  localparam logic [2:0] S_RD_REQ   = 3'd2;
  localparam logic [2:0] S_RD_WAIT  = 3'd3;
  localparam logic [2:0] S_CLR_WR   = 3'd4;
  localparam logic [2:0] S_DISPATCH = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] MASK_A    = ADDR_WIDTH'(MASK_ADDR);
  localparam logic [ADDR_WIDTH-1:0] CAPTURE_A = ADDR_WIDTH'(CAPTURE_ADDR);

  logic [2:0]            state;
  logic [2:0]            next_state;
  logic [DATA_WIDTH-1:0] pend;
  logic [DATA_WIDTH-1:0] pend_after;
  logic                  cfg_load_pending;
  logic                  accept;
  logic                  rd_data_now;
  logic                  rd_zero;
  logic                  evt_fire;

  // Index of the lowest set bit; scanning downwards lets the lowest win.
  function automatic logic [ID_WIDTH-1:0] lowest_index(input logic [DATA_WIDTH-1:0] v);
    logic [ID_WIDTH-1:0] idx;
    idx = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_WIDTH'(i);
    end
    return idx;
  endfunction

  assign accept   = (avm_read | avm_write) & ~avm_waitrequest;
  assign evt_fire = evt_valid & evt_ready;
  assign rd_zero  = (avm_readdata == '0);
  // Read data counts in RD_WAIT, or in RD_REQ when the slave answers in the
  // very cycle it accepts the read.
  assign rd_data_now = avm_readdatavalid &
                       ((state == S_RD_WAIT) | ((state == S_RD_REQ) & avm_read & accept));
  assign pend_after = pend & ~(DATA_WIDTH'(1) << evt_id);

  // Next-state decision for the service sequence.
  always_comb begin
    // NOTE: default assignment first so every path assigns next_state and no latch is inferred.
    next_state = state;
    case (state)
      S_MASK_WR:  if (avm_write && !avm_waitrequest) next_state = S_IDLE;
      S_IDLE: begin
        if (cfg_load_pending) next_state = S_MASK_WR;
        else if (irq_in)      next_state = S_RD_REQ;
      end
      S_RD_REQ: begin
        if (accept) begin
          if (rd_data_now) next_state = rd_zero ? S_IDLE : S_CLR_WR;
          else             next_state = S_RD_WAIT;
        end
      end
      S_RD_WAIT:  if (avm_readdatavalid) next_state = rd_zero ? S_IDLE : S_CLR_WR;
      S_CLR_WR:   if (accept) next_state = S_DISPATCH;
      S_DISPATCH: if (evt_fire && (pend_after == '0)) next_state = S_IDLE;
      default:    next_state = S_MASK_WR;
    endcase
  end

  // Registered state, Avalon command, event and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_MASK_WR;
      pend             <= '0;
      cfg_load_pending <= 1'b1;
      avm_address      <= '0;
      avm_read         <= 1'b0;
      avm_write        <= 1'b0;
      avm_writedata    <= '0;
      evt_valid        <= 1'b0;
      evt_id           <= '0;
      busy             <= 1'b0;
      spurious_cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state <= next_state;
      busy  <= (next_state != S_IDLE);

      // A new request wins over the clear so a late pulse is never lost.
      if (cfg_load)                              cfg_load_pending <= 1'b1;
      else if ((state == S_MASK_WR) && accept)   cfg_load_pending <= 1'b0;

      case (state)
        S_MASK_WR: begin
          // Out of reset the write has not been issued yet; issue it here.
          if (!avm_write) begin
            avm_write     <= 1'b1;
            avm_address   <= MASK_A;
            avm_writedata <= cfg_mask;
          end else if (!avm_waitrequest) begin
            avm_write <= 1'b0;
          end
        end
        S_IDLE: begin
          if (cfg_load_pending) begin
            avm_write     <= 1'b1;
            avm_address   <= MASK_A;
            avm_writedata <= cfg_mask;
          end else if (irq_in) begin
            avm_read    <= 1'b1;
            avm_address <= CAPTURE_A;
          end
        end
        S_RD_REQ: if (accept) avm_read <= 1'b0;
        S_CLR_WR: begin
          if (accept) begin
            avm_write <= 1'b0;
            evt_valid <= 1'b1;
            evt_id    <= lowest_index(pend);
          end
        end
        S_DISPATCH: begin
          if (evt_fire) begin
            evt_valid <= 1'b0;
            pend      <= pend_after;
          end else if (!evt_valid && (pend != '0)) begin
            evt_valid <= 1'b1;
            evt_id    <= lowest_index(pend);
          end
        end
        default: ;
      endcase

      // Capture read data: zero is a spurious IRQ, otherwise start the clear.
      if (rd_data_now) begin
        if (rd_zero) begin
          if (spurious_cnt != 8'hFF) spurious_cnt <= spurious_cnt + 8'd1;
        end else begin
          pend          <= avm_readdata;
          avm_write     <= 1'b1;
          avm_address   <= CAPTURE_A;
          avm_writedata <= avm_readdata;
        end
      end
    end
  end

endmodule
